// File: rtl/rgb_pwm_fader_if.sv
// Control and LED signal bundle for the RGB PWM fader.
// The master drives the run/target controls; the slave returns the PWM outputs.
interface rgb_pwm_fader_if #(
    parameter int CHANNELS = 3,
    parameter int DUTY_W   = 4
);
    logic                         enable;
    logic                         mode;
    logic [CHANNELS*DUTY_W-1:0]   duty_in;
    logic [CHANNELS-1:0]          led;
    logic                         frame_tick;

    modport master (
        output enable, mode, duty_in,
        input  led, frame_tick
    );

    modport slave (
        input  enable, mode, duty_in,
        output led, frame_tick
    );
endinterface

// File: rtl/rgb_pwm_fader.sv
// Multi-channel LED PWM generator with direct or one-step-per-frame fading.
// Target duties are sampled only at frame boundaries, so a running frame is never glitched.
module rgb_pwm_fader #(
    parameter int CHANNELS = 3,
    parameter int DUTY_W   = 4,
    parameter int PRESCALE = 3125
) (
    input  logic              clock,
    input  logic              reset,
    rgb_pwm_fader_if.slave    bus
);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0] STEP_LAST = '1;

    logic [PS_W-1:0]     presc;
    logic [DUTY_W-1:0]   step;
    logic [DUTY_W-1:0]   level [CHANNELS];
    logic [CHANNELS-1:0] led_q;
    logic                tick_q;
    logic                step_tick;
    logic                frame_end;

    // One level step toward the target; the comparison guard keeps it inside 0..max.
    function automatic logic [DUTY_W-1:0] fade_step(input logic [DUTY_W-1:0] cur,
                                                     input logic [DUTY_W-1:0] tgt);
        if (tgt > cur)
            return cur + 1'b1;
        else if (tgt < cur)
            return cur - 1'b1;
        else
            return cur;
    endfunction

    assign step_tick = bus.enable && (presc == PS_LAST);
    assign frame_end = step_tick && (step == STEP_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc  <= '0;
            step   <= '0;
            led_q  <= '0;
            tick_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++)
                level[c] <= '0;
        end else if (!bus.enable) begin
            // Levels are deliberately held so the next enable resumes the same brightness.
            presc  <= '0;
            step   <= '0;
            led_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            presc  <= step_tick ? '0 : presc + 1'b1;
            if (step_tick)
                step <= step + 1'b1;
            tick_q <= frame_end;
            for (int c = 0; c < CHANNELS; c++) begin
                led_q[c] <= (level[c] > step);
                if (frame_end)
                    level[c] <= bus.mode ? fade_step(level[c], bus.duty_in[c*DUTY_W +: DUTY_W])
                                         : bus.duty_in[c*DUTY_W +: DUTY_W];
            end
        end
    end

    assign bus.led        = led_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed bench for rgb_pwm_fader with CHANNELS=3, DUTY_W=2, PRESCALE=4 (16-cycle frames).
module tb_rgb_pwm_fader;
    localparam int CH = 3;
    localparam int DW = 2;
    localparam int PS = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    rgb_pwm_fader_if #(.CHANNELS(CH), .DUTY_W(DW)) bus ();

    rgb_pwm_fader #(.CHANNELS(CH), .DUTY_W(DW), .PRESCALE(PS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       mode;
        logic [5:0] duty;
        int         e0;
        int         e1;
        int         e2;
    } vec_t;

    vec_t tbl [16];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Samples one 16-cycle frame on falling edges; optionally changes duty_in after sample chg_at.
    task automatic run_frame(input int chg_at, input logic [5:0] chg_duty,
                             output int h0, output int h1, output int h2, output int tmask);
        h0 = 0; h1 = 0; h2 = 0; tmask = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clock);
            h0 += int'(bus.led[0]);
            h1 += int'(bus.led[1]);
            h2 += int'(bus.led[2]);
            if (bus.frame_tick) tmask |= (1 << (i - 1));
            if (i == chg_at) bus.duty_in = chg_duty;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, h1, h2, tm;
        int led_any, tick_any;

        tbl[0]  = '{1'b0, 6'h31, 0, 0, 0};
        tbl[1]  = '{1'b0, 6'h31, 4, 0, 12};
        tbl[2]  = '{1'b0, 6'h31, 4, 0, 12};
        tbl[3]  = '{1'b0, 6'h00, 4, 0, 12};
        tbl[4]  = '{1'b1, 6'h03, 0, 0, 0};
        tbl[5]  = '{1'b1, 6'h03, 4, 0, 0};
        tbl[6]  = '{1'b1, 6'h03, 8, 0, 0};
        tbl[7]  = '{1'b1, 6'h03, 12, 0, 0};
        tbl[8]  = '{1'b1, 6'h00, 12, 0, 0};
        tbl[9]  = '{1'b1, 6'h00, 8, 0, 0};
        tbl[10] = '{1'b1, 6'h00, 4, 0, 0};
        tbl[11] = '{1'b1, 6'h34, 0, 0, 0};
        tbl[12] = '{1'b1, 6'h34, 0, 4, 4};
        tbl[13] = '{1'b1, 6'h00, 0, 4, 8};
        tbl[14] = '{1'b0, 6'h09, 0, 0, 4};
        tbl[15] = '{1'b0, 6'h09, 4, 8, 0};

        // Reset held with everything requesting full brightness
        reset       = 1'b0;
        bus.enable  = 1'b1;
        bus.mode    = 1'b0;
        bus.duty_in = 6'h3F;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("reset_led", int'(bus.led), 0);
            check("reset_tick", int'(bus.frame_tick), 0);
        end
        reset = 1'b1;

        // Frame-by-frame vectors; row 0 is the all-dark first frame after reset
        for (int r = 0; r < 16; r++) begin
            bus.mode    = tbl[r].mode;
            bus.duty_in = tbl[r].duty;
            run_frame(0, 6'h00, h0, h1, h2, tm);
            check($sformatf("row%0d_led0", r), h0, tbl[r].e0);
            check($sformatf("row%0d_led1", r), h1, tbl[r].e1);
            check($sformatf("row%0d_led2", r), h2, tbl[r].e2);
            check($sformatf("row%0d_tick", r), tm, 32'h8000);
        end

        // Mid-frame duty change must not disturb the running frame (levels now 1,2,0)
        bus.mode    = 1'b0;
        bus.duty_in = 6'h01;
        run_frame(0, 6'h00, h0, h1, h2, tm);
        check("pre_mid_led0", h0, 4);
        check("pre_mid_led1", h1, 8);
        run_frame(8, 6'h03, h0, h1, h2, tm);
        check("mid_change_led0", h0, 4);
        check("mid_change_tick", tm, 32'h8000);
        run_frame(0, 6'h00, h0, h1, h2, tm);
        check("after_change_led0", h0, 12);

        // Enable dropped mid-frame, level 3 on channel 0
        for (int i = 0; i < 5; i++) @(negedge clock);
        check("en_pre_led0", int'(bus.led[0]), 1);
        bus.enable = 1'b0;
        @(negedge clock);
        check("dis_led", int'(bus.led), 0);
        check("dis_tick", int'(bus.frame_tick), 0);
        check("dis_presc", int'(dut.presc), 0);
        check("dis_step", int'(dut.step), 0);
        check("dis_level0", int'(dut.level[0]), 3);
        led_any = 0; tick_any = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            led_any  |= int'(bus.led);
            tick_any |= int'(bus.frame_tick);
        end
        check("dis_hold_led", led_any, 0);
        check("dis_hold_tick", tick_any, 0);
        check("dis_hold_level0", int'(dut.level[0]), 3);
        bus.enable = 1'b1;
        run_frame(0, 6'h00, h0, h1, h2, tm);
        check("reen_led0", h0, 12);
        check("reen_led2", h2, 0);
        check("reen_tick", tm, 32'h8000);

        // Asynchronous reset between edges during a fade-down
        bus.mode    = 1'b1;
        bus.duty_in = 6'h00;
        run_frame(0, 6'h00, h0, h1, h2, tm);
        check("fade_dn_led0", h0, 12);
        @(negedge clock);
        @(negedge clock);
        check("pre_areset_led0", int'(bus.led[0]), 1);
        #2 reset = 1'b0;
        #1;
        check("areset_led", int'(bus.led), 0);
        check("areset_tick", int'(bus.frame_tick), 0);
        check("areset_level0", int'(dut.level[0]), 0);
        @(negedge clock);
        reset       = 1'b1;
        bus.duty_in = 6'h03;
        run_frame(0, 6'h00, h0, h1, h2, tm);
        check("post_reset_led0", h0, 0);
        check("post_reset_tick", tm, 32'h8000);
        run_frame(0, 6'h00, h0, h1, h2, tm);
        check("post_reset_fade_led0", h0, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rgb_pwm_fader.md
RGB_PWM_FADER -- requirements
Module: rgb_pwm_fader

Interface
REQ-001 SHALL have parameter CHANNELS, default 3: number of independent PWM LED channels.
REQ-002 SHALL have parameter DUTY_W, default 4: duty resolution in bits, giving 2^DUTY_W steps per frame.
REQ-003 SHALL have parameter PRESCALE, default 3125: number of clock cycles per PWM step (legal range >= 2).
REQ-004 SHALL have port clock, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port enable, input, 1 bit: 1 = run; 0 = hold the channels dark.
REQ-007 SHALL have port mode, input, 1 bit: 0 = direct (jump to target); 1 = fade (step toward target).
REQ-008 SHALL have port duty_in, input, CHANNELS*DUTY_W bits: target duty per channel, with channel c in bits [c*DUTY_W +: DUTY_W].
REQ-009 SHALL have port led, output, CHANNELS bits: registered PWM output, one bit per channel.
REQ-010 SHALL have port frame_tick, output, 1 bit: registered pulse lasting 1 cycle, asserted at each frame end.

Function
REQ-011 SHALL keep a prescaler counter counting 0..PRESCALE-1; step_tick is asserted when the counter = PRESCALE-1 and enable = 1; the counter then wraps to 0.
REQ-012 SHALL keep a DUTY_W-bit step counter that increments on step_tick and wraps from 2^DUTY_W-1 to 0; one frame = PRESCALE*2^DUTY_W cycles.
REQ-013 SHALL define frame_end as step_tick AND step counter = 2^DUTY_W-1; frame_tick SHALL be registered high on the edge following frame_end and low otherwise.
REQ-014 SHALL hold a DUTY_W-bit level register per channel, updated only on frame_end, on the same edge on which the step counter wraps to 0.
REQ-015 In mode 0, SHALL set level[c] <= duty_in[c] on frame_end.
REQ-016 In mode 1, SHALL on frame_end set level[c] <= level[c]+1 if duty_in[c] > level[c], level[c]-1 if duty_in[c] < level[c], and leave it unchanged if they are equal; each channel is independent.
REQ-017 SHALL never let level leave 0..2^DUTY_W-1; there is no wrap-around and no overflow.
REQ-018 SHALL register led[c] <= (enable AND level[c] > step counter) every cycle, comparing unsigned values of the current register contents.
REQ-019 SHALL ignore changes of duty_in and mode between frame ends, so the current frame is never glitched.
REQ-020 When enable = 0, SHALL clear the prescaler and step counter to 0 synchronously, drive led = 0 from the next edge, keep frame_tick = 0, and hold the level registers.
REQ-021 When enable rises, SHALL start a fresh frame from step 0 using the held levels.
REQ-022 Level 0 SHALL produce a led that is never high; level L SHALL produce a led that is high for L*PRESCALE cycles per frame.

Reset
REQ-023 While reset = 0, SHALL immediately (asynchronously) clear the prescaler, step counter, all level registers, led and frame_tick to 0.
REQ-024 After reset is released, SHALL begin counting on the first rising clock edge; the first frame is all-dark because level = 0.
REQ-025 Reset asserted mid-frame or mid-fade SHALL discard all progress; no state survives reset.

Verification (CHANNELS=3, DUTY_W=2, PRESCALE=4, frame = 16 cycles)
REQ-026 Reset test: hold reset=0 for 3 cycles with enable=1 and duty_in=6'h3F -> led=000 and frame_tick=0 throughout; first frame after release is all-dark, and frame_tick pulses after 16 cycles.
REQ-027 Direct mode test: mode=0, duty_in={ch2=3, ch1=0, ch0=1} -> from the second frame on, per 16 cycles led[0] is high 4 cycles, led[1] 0 cycles and led[2] 12 cycles.
REQ-028 Fade mode test: mode=1, level 0, duty_in ch0=3 -> high count per frame for led[0] = 4, 8, 12, 12...; then duty_in ch0=0 -> high count = 8, 4, 0.
REQ-029 Mid-frame change test: change duty_in ch0 from 1 to 3 at step 2 -> that frame still gives 4 high cycles; the next frame gives 12.
REQ-030 Enable test: set enable=0 mid-frame -> led=000 on the next edge, counters read 0, and levels are held; set enable=1 -> a full 16-cycle frame with the held levels, with frame_tick 16 cycles after enable rises.
REQ-031 Async reset test: assert reset=0 between clock edges during a fade -> led clears without waiting for an edge; after release, levels restart from 0.
